power_iter_engine: RTL

- Self-sequenced power-iteration engine for an N x N fixed-point matrix. Repeats multiply, normalise and compare until convergence or an iteration limit.
- Successor to the fixed 4x4 dominant-eigenvector datapath. N, WIDTH and FRAC are parametrised, control is integrated, and the engine adds a tolerance test, an iteration cap and fault reporting.
- Sits between the matrix loader and the result display/readout logic.

---
 rtl/power_iter_engine.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/power_iter_engine.sv
// power_iter_engine: self-sequenced power-iteration engine for an N x N
// signed fixed-point (Q FRAC) matrix. It repeats
//   y = A*v, v_new = y scaled down by a power of two so that max|v_new| <= ONE,
//   max_diff = max |v_new - v_old|
// until max_diff <= tol, the iteration cap is reached, or y comes out all zero.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begin a run; sampled only in IDLE
//   mat_in           N*N*WIDTH row-major matrix, held stable while busy
//   v_init           N*WIDTH initial vector, captured on start
//   tol              WIDTH-bit unsigned convergence tolerance, captured on start
//   max_iter         ITER_W iteration cap, captured on start (0 acts as 1)
//   busy             high while a run is in progress
//   done             one-cycle end-of-run pulse
//   converged        last run ended with max_diff <= tol
//   fault            last run ended on an all-zero y vector
//   v_out            current normalised vector (packed like v_init)
//   max_diff         max |v_new[i] - v_old[i]| of the last iteration
//   iter_count       iterations completed in the current/last run
module power_iter_engine #(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int ITER_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N*N*WIDTH-1:0]   mat_in,
  input  logic [N*WIDTH-1:0]     v_init,
  input  logic [WIDTH-1:0]       tol,
  input  logic [ITER_W-1:0]      max_iter,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic                   fault,
  output logic [N*WIDTH-1:0]     v_out,
  output logic [WIDTH-1:0]       max_diff,
  output logic [ITER_W-1:0]      iter_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*WIDTH + $clog2(N);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int SAT_I = (1 << (WIDTH-1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_I);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;
  localparam logic [WIDTH-1:0]        SAT_U  = WIDTH'(SAT_I);
  localparam logic [WIDTH:0]          ONE_U  = {{WIDTH{1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_NORM  = 3'd2,
    ST_DIFF  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  // y values are held in the symmetric range, so the magnitude never overflows
  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  state_t state_r, state_next_s;

  logic signed [WIDTH-1:0] v_old_r [N];
  logic signed [WIDTH-1:0] v_new_r [N];
  logic signed [WIDTH-1:0] y_r     [N];
  logic [IDX_W-1:0]        idx_r;
  logic [WIDTH-1:0]        tol_r;
  logic [ITER_W-1:0]       max_iter_r;
  logic [WIDTH-1:0]        diff_r;
  logic                    busy_r, done_r, converged_r, fault_r;
  logic [N*WIDTH-1:0]      v_out_r;
  logic [WIDTH-1:0]        max_diff_r;
  logic [ITER_W-1:0]       iter_r;

  logic signed [WIDTH-1:0]   a_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]   acc_s, acc_sh_s;
  logic signed [WIDTH-1:0]   y_sat_s;
  logic [WIDTH-1:0]          m_s;
  logic [SH_W-1:0]           shift_s;
  logic signed [WIDTH-1:0]   v_shift_s [N];
  logic signed [WIDTH:0]     d_s;
  logic [WIDTH:0]            ad_s;
  logic [WIDTH-1:0]          dsat_s, diff_max_s;
  logic [ITER_W-1:0]         iter_inc_s;
  logic                      last_s, conv_s, cap_s, accept_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign converged  = converged_r;
  assign fault      = fault_r;
  assign v_out      = v_out_r;
  assign max_diff   = max_diff_r;
  assign iter_count = iter_r;

  assign last_s     = (idx_r == IDX_W'(N-1));
  assign iter_inc_s = (iter_r == {ITER_W{1'b1}}) ? iter_r : iter_r + ITER_W'(1);
  assign conv_s     = (diff_r <= tol_r);
  assign cap_s      = (iter_inc_s >= max_iter_r);
  // a start during the done cycle is ignored; it is taken from the next IDLE cycle
  assign accept_s   = start && !done_r;

  // Row dot product for the current MULT row, rescaled and saturated
  always_comb begin
    a_s    = '0;
    prod_s = '0;
    acc_s  = '0;
    for (int j = 0; j < N; j++) begin
      a_s    = mat_in[(int'(idx_r)*N + j)*WIDTH +: WIDTH];
      prod_s = (2*WIDTH)'(a_s) * (2*WIDTH)'(v_old_r[j]);
      acc_s  = acc_s + ACC_W'(prod_s);
    end
    acc_sh_s = acc_s >>> FRAC;
    if (acc_sh_s > SAT_HI) begin
      y_sat_s = WIDTH'(SAT_I);
    end else if (acc_sh_s < SAT_LO) begin
      y_sat_s = -WIDTH'(SAT_I);
    end else begin
      y_sat_s = acc_sh_s[WIDTH-1:0];
    end
  end

  // Peak magnitude of y and the smallest right shift that brings it to <= ONE
  always_comb begin
    m_s = '0;
    for (int i = 0; i < N; i++) begin
      if (abs_w(y_r[i]) > m_s) begin
        m_s = abs_w(y_r[i]);
      end else begin
        m_s = m_s;
      end
    end
    shift_s = SH_W'(WIDTH-1);
    // walk downwards so the last hit is the smallest qualifying shift
    for (int k = WIDTH-1; k >= 0; k--) begin
      if (({1'b0, m_s} >> k) <= ONE_U) begin
        shift_s = SH_W'(k);
      end else begin
        shift_s = shift_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      v_shift_s[i] = y_r[i] >>> shift_s;
    end
  end

  // Saturated |v_new - v_old| for the current DIFF element and running maximum
  always_comb begin
    d_s    = {v_new_r[idx_r][WIDTH-1], v_new_r[idx_r]} - {v_old_r[idx_r][WIDTH-1], v_old_r[idx_r]};
    ad_s   = d_s[WIDTH] ? (WIDTH+1)'(-d_s) : (WIDTH+1)'(d_s);
    dsat_s = (ad_s > {1'b0, SAT_U}) ? SAT_U : ad_s[WIDTH-1:0];
    diff_max_s = (dsat_s > diff_r) ? dsat_s : diff_r;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = accept_s ? ST_MULT : ST_IDLE;
      ST_MULT:  state_next_s = last_s ? ST_NORM : ST_MULT;
      ST_NORM:  state_next_s = (m_s == '0) ? ST_IDLE : ST_DIFF;
      ST_DIFF:  state_next_s = last_s ? ST_CHECK : ST_DIFF;
      ST_CHECK: state_next_s = (conv_s || cap_s) ? ST_IDLE : ST_MULT;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        v_old_r[i] <= '0;
        v_new_r[i] <= '0;
        y_r[i]     <= '0;
      end
      idx_r       <= '0;
      tol_r       <= '0;
      max_iter_r  <= '0;
      diff_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      converged_r <= 1'b0;
      fault_r     <= 1'b0;
      v_out_r     <= '0;
      max_diff_r  <= '0;
      iter_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int i = 0; i < N; i++) begin
              v_old_r[i] <= v_init[i*WIDTH +: WIDTH];
            end
            v_out_r     <= v_init;
            tol_r       <= tol;
            max_iter_r  <= (max_iter == '0) ? ITER_W'(1) : max_iter;
            iter_r      <= '0;
            converged_r <= 1'b0;
            fault_r     <= 1'b0;
            busy_r      <= 1'b1;
            idx_r       <= '0;
          end
        end
        ST_MULT: begin
          y_r[idx_r] <= y_sat_s;
          idx_r      <= last_s ? '0 : idx_r + IDX_W'(1);
        end
        ST_NORM: begin
          if (m_s == '0) begin
            fault_r <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            for (int i = 0; i < N; i++) begin
              v_new_r[i] <= v_shift_s[i];
            end
          end
          diff_r <= '0;
          idx_r  <= '0;
        end
        ST_DIFF: begin
          diff_r <= diff_max_s;
          idx_r  <= last_s ? '0 : idx_r + IDX_W'(1);
        end
        ST_CHECK: begin
          max_diff_r <= diff_r;
          for (int i = 0; i < N; i++) begin
            v_old_r[i]                  <= v_new_r[i];
            v_out_r[i*WIDTH +: WIDTH]   <= v_new_r[i];
          end
          iter_r <= iter_inc_s;
          idx_r  <= '0;
          if (conv_s) begin
            converged_r <= 1'b1;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end else if (cap_s) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
